// File: rtl/seq_stream_ctrl_pkg.sv
// rtl/seq_stream_ctrl_pkg.sv - shared types and defaults for the word-to-serial detector controller
package seq_stream_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CW    = 8;

    // Hit counter per word must hold 0..WIDTH inclusive.
    function automatic int hit_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - MSB-first load/shift register with bit counter and last-bit flag
module seq_bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] bit_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sreg    <= data;
            bit_cnt <= LAST_IDX;
        end else if (shift) begin
            sreg    <= {sreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - CNT_W'(1);
        end
    end

    assign msb  = sreg[WIDTH-1];
    assign last = (bit_cnt == '0);

endmodule

// File: rtl/seq_stream_ctrl.sv
// rtl/seq_stream_ctrl.sv - feeds words MSB-first into a serial detector and counts hits; SEQ_STREAM_CTRL_STREAM_EN enables zero-bubble chaining
module seq_stream_ctrl
    import seq_stream_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       abort,
    input  logic                       clr_total,
    output logic                       det_x,
    input  logic                       det_z,
    output logic                       det_rst,
    output logic                       busy,
    output logic                       word_done,
    output logic [$clog2(WIDTH+1)-1:0] word_hits,
    output logic [CW-1:0]              total_hits
);

    localparam int HW = hit_w(WIDTH);
    localparam logic [CW-1:0] TOT_MAX = '1;

    state_t        state;
    state_t        next_state;
    logic          ser_msb;
    logic          ser_last;
    logic          accept;
    logic          shift_en;
    logic [HW-1:0] acc;

`ifdef SEQ_STREAM_CTRL_STREAM_EN
    // Ready in the last bit slot lets the next word follow with no gap.
    assign in_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && ser_last && !abort);
`else
    assign in_ready = (state == ST_IDLE);
`endif

    assign accept   = in_valid && in_ready;
    assign shift_en = (state == ST_SHIFT) && !accept;
    assign busy     = (state == ST_SHIFT);
    assign det_x    = (state == ST_SHIFT) && ser_msb;

    seq_bit_serializer #(.WIDTH(WIDTH)) u_ser (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (shift_en),
        .data  (in_data),
        .msb   (ser_msb),
        .last  (ser_last)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (abort)
                    next_state = ST_IDLE;
                else if (ser_last)
                    next_state = accept ? ST_SHIFT : ST_IDLE;
            end
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            det_rst    <= 1'b1;
            word_done  <= 1'b0;
            word_hits  <= '0;
            total_hits <= '0;
            acc        <= '0;
        end else begin
            state     <= next_state;
            det_rst   <= (next_state != ST_SHIFT);
            word_done <= 1'b0;

            if (state == ST_IDLE) begin
                if (accept)
                    acc <= '0;
            end else if (!abort) begin
                if (ser_last) begin
                    word_done <= 1'b1;
                    word_hits <= acc + HW'(det_z);
                    acc       <= '0;
                end else begin
                    acc <= acc + HW'(det_z);
                end
            end

            // Hits seen in an aborted cycle still reach the running total.
            if (clr_total)
                total_hits <= '0;
            else if ((state == ST_SHIFT) && det_z && (total_hits != TOT_MAX))
                total_hits <= total_hits + CW'(1);
        end
    end

endmodule
